// File: rtl/if_id_buffer.sv
// if_id_buffer: fetch-to-decode FIFO of {pc, instr} with flush, HALT stop and misaligned-PC flag
module if_id_buffer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [WIDTH-1:0] if_instr,
    input  logic [WIDTH-1:0] if_pc,
    output logic             if_ready,
    output logic             id_valid,
    output logic [WIDTH-1:0] id_instr,
    output logic [WIDTH-1:0] id_pc,
    output logic [WIDTH-1:0] id_pc_inc,
    input  logic             id_ready,
    input  logic             flush,
    output logic             halt_seen,
    output logic             err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [WIDTH-1:0] NOP = WIDTH'(16'h0800);
    logic [WIDTH-1:0] instr_q [DEPTH];
    logic [WIDTH-1:0] pc_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0] count_q, count_d;
    logic halt_q, halt_d, err_q, err_d, push, pop;
    assign if_ready  = (count_q != FULL) & ~halt_q & ~flush;
    assign id_valid  = count_q != '0;
    assign push      = if_valid & if_ready;
    assign pop       = id_valid & id_ready;
    assign halt_seen = halt_q;
    assign err       = err_q;
    // Empty head presents a NOP so decode never sees stale storage
    assign id_instr  = id_valid ? instr_q[rptr_q] : NOP;
    assign id_pc     = id_valid ? pc_q[rptr_q] : '0;
    assign id_pc_inc = id_valid ? pc_q[rptr_q] + WIDTH'(2) : '0;
    always_comb begin
        wptr_d  = flush ? '0 : wptr_q + AW'(push);
        rptr_d  = flush ? '0 : rptr_q + AW'(pop);
        count_d = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
        halt_d  = ~flush & (halt_q | (push & (if_instr[WIDTH-1 -: 5] == 5'b0)));
        err_d   = err_q | (push & if_pc[0]);
    end
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wptr_q] <= if_instr;
            pc_q[wptr_q]    <= if_pc;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            halt_q  <= halt_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: scoreboard bench for if_id_buffer, scenario tasks run in sequence
module tb_if_id_buffer;
    localparam int DEPTH = 2;
    logic clk = 1'b0, rst = 1'b1;
    logic if_valid = 1'b0, id_ready = 1'b0, flush = 1'b0;
    logic [15:0] if_instr = '0, if_pc = '0;
    logic if_ready, id_valid, halt_seen, err;
    logic [15:0] id_instr, id_pc, id_pc_inc;
    logic [31:0] sb[$];
    logic m_halt = 1'b0, m_err = 1'b0;
    int total = 0, bad = 0;

    if_id_buffer #(.DEPTH(DEPTH), .WIDTH(16)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(if_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc_inc(id_pc_inc), .id_ready(id_ready), .flush(flush),
        .halt_seen(halt_seen), .err(err)
    );

    always #5 clk = ~clk;

    // One cycle: drive, compare head against scoreboard, update expectations, clock
    task automatic cyc(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic rdy, input logic fl, input string tag);
        logic exp_rdy;
        logic [15:0] e_pc, e_ins, e_inc;
        if_valid = v; if_instr = ins; if_pc = pc; id_ready = rdy; flush = fl;
        #1;
        exp_rdy = (sb.size() < DEPTH) && !m_halt && !fl;
        e_pc  = (sb.size() != 0) ? sb[0][31:16] : 16'h0000;
        e_ins = (sb.size() != 0) ? sb[0][15:0] : 16'h0800;
        e_inc = (sb.size() != 0) ? e_pc + 16'd2 : 16'h0000;
        total++;
        if (if_ready !== exp_rdy) begin bad++; $display("FAIL %s if_ready got=%b exp=%b", tag, if_ready, exp_rdy); end
        total++;
        if (id_valid !== (sb.size() != 0)) begin bad++; $display("FAIL %s id_valid got=%b exp=%b", tag, id_valid, sb.size() != 0); end
        total++;
        if (id_pc !== e_pc) begin bad++; $display("FAIL %s id_pc got=%h exp=%h", tag, id_pc, e_pc); end
        total++;
        if (id_instr !== e_ins) begin bad++; $display("FAIL %s id_instr got=%h exp=%h", tag, id_instr, e_ins); end
        total++;
        if (id_pc_inc !== e_inc) begin bad++; $display("FAIL %s id_pc_inc got=%h exp=%h", tag, id_pc_inc, e_inc); end
        if (fl) begin
            sb.delete();
            m_halt = 1'b0;
        end else begin
            if (sb.size() != 0 && rdy) void'(sb.pop_front());
            if (v && exp_rdy) begin
                sb.push_back({pc, ins});
                if (ins[15:11] == 5'b0) m_halt = 1'b1;
                if (pc[0]) m_err = 1'b1;
            end
        end
        @(posedge clk); #1;
        total++;
        if (halt_seen !== m_halt) begin bad++; $display("FAIL %s halt_seen got=%b exp=%b", tag, halt_seen, m_halt); end
        total++;
        if (err !== m_err) begin bad++; $display("FAIL %s err got=%b exp=%b", tag, err, m_err); end
    endtask

    task automatic reset_pulse(input string tag);
        if_valid = 1'b0; id_ready = 1'b0; flush = 1'b0;
        #2 rst = 1'b1;
        #1;
        sb.delete(); m_halt = 1'b0; m_err = 1'b0;
        total++;
        if (id_valid !== 1'b0) begin bad++; $display("FAIL %s rst id_valid got=%b exp=0", tag, id_valid); end
        total++;
        if (id_instr !== 16'h0800) begin bad++; $display("FAIL %s rst id_instr got=%h exp=0800", tag, id_instr); end
        total++;
        if (id_pc !== 16'h0 || id_pc_inc !== 16'h0) begin bad++; $display("FAIL %s rst id_pc/inc got=%h/%h exp=0/0", tag, id_pc, id_pc_inc); end
        total++;
        if (halt_seen !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL %s rst halt/err got=%b/%b exp=0/0", tag, halt_seen, err); end
        @(posedge clk); #1 rst = 1'b0;
        #1;
        total++;
        if (if_ready !== 1'b1) begin bad++; $display("FAIL %s rst if_ready got=%b exp=1", tag, if_ready); end
    endtask

    task automatic test_reset();
        reset_pulse("reset_init");
        cyc(1, 16'hC001, 16'h0000, 0, 0, "rst_fill0");
        cyc(1, 16'hC102, 16'h0002, 0, 0, "rst_fill1");
        reset_pulse("reset_mid");
    endtask

    task automatic test_fill();
        cyc(1, 16'hC001, 16'h0000, 0, 0, "fill0");
        cyc(1, 16'hC102, 16'h0002, 0, 0, "fill1");
        cyc(1, 16'hC203, 16'h0004, 0, 0, "fill_full");
        cyc(0, 16'h0000, 16'h0000, 1, 0, "drain0");
        cyc(0, 16'h0000, 16'h0000, 1, 0, "drain1");
        cyc(0, 16'h0000, 16'h0000, 0, 0, "drained");
    endtask

    task automatic test_back_to_back();
        cyc(1, 16'hA000, 16'h0010, 0, 0, "stream_prime");
        for (int i = 1; i < 8; i++)
            cyc(1, 16'hA000 + 16'(i), 16'h0010 + 16'(2 * i), 1, 0, "stream");
        total++;
        if (sb.size() != 1 || id_valid !== 1'b1) begin bad++; $display("FAIL stream_count got_valid=%b exp=1 depth=%0d", id_valid, sb.size()); end
        cyc(0, 16'h0000, 16'h0000, 1, 0, "stream_drain");
        cyc(0, 16'h0000, 16'h0000, 0, 0, "stream_empty");
    endtask

    task automatic test_flush();
        cyc(1, 16'hB001, 16'h0040, 0, 0, "fl_fill0");
        cyc(1, 16'hB002, 16'h0042, 0, 0, "fl_fill1");
        cyc(1, 16'hB003, 16'h0044, 1, 1, "flush_push");
        cyc(1, 16'hB100, 16'h0100, 0, 0, "post_flush");
        cyc(0, 16'h0000, 16'h0000, 1, 0, "post_deliver");
        cyc(0, 16'h0000, 16'h0000, 0, 0, "post_empty");
    endtask

    task automatic test_halt();
        cyc(1, 16'h4000, 16'h0200, 0, 0, "halt_pre");
        cyc(1, 16'h0000, 16'h0202, 0, 0, "halt_push");
        cyc(1, 16'hC000, 16'h0204, 1, 0, "halt_pop0");
        cyc(1, 16'hC000, 16'h0206, 1, 0, "halt_pop1");
        cyc(1, 16'hC000, 16'h0208, 0, 0, "halt_block");
        cyc(0, 16'h0000, 16'h0000, 0, 1, "halt_flush");
        cyc(0, 16'h0000, 16'h0000, 0, 0, "halt_clear");
    endtask

    task automatic test_wrap_err();
        cyc(1, 16'hA500, 16'hFFFE, 0, 0, "wrap_push");
        cyc(0, 16'h0000, 16'h0000, 1, 0, "wrap_pop");
        cyc(1, 16'hA600, 16'h0003, 0, 0, "mis_push");
        cyc(0, 16'h0000, 16'h0000, 1, 0, "mis_pop");
        cyc(0, 16'h0000, 16'h0000, 0, 1, "mis_flush");
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
        reset_pulse("err_rst");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_back_to_back();
        test_flush();
        test_halt();
        test_wrap_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
